// File: rtl/cte_rgb_out_buffer_pkg.sv
// cte_rgb_out_buffer_pkg: shared pixel type and sizing helper for the CTE RGB output buffer.
package cte_rgb_out_buffer_pkg;
    localparam int RGB_W = 24;
    typedef logic [RGB_W-1:0] rgb_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/cte_rgb_out_buffer_if.sv
// cte_rgb_out_buffer_if: CTE pixel capture side and frame-sink drain side of the output buffer.
interface cte_rgb_out_buffer_if
    import cte_rgb_out_buffer_pkg::*;
#(
    parameter int LVL_W = 5
);
    logic             pix_valid;
    rgb_t             pix_rgb;
    logic             dout_valid;
    logic             dout_ready;
    rgb_t             dout_rgb;
    logic             dout_last;
    logic [LVL_W-1:0] level;
    logic             almost_full;
    logic             overflow;
    logic             clr_ovf;
    modport master (
        output pix_valid, pix_rgb, dout_ready, clr_ovf,
        input  dout_valid, dout_rgb, dout_last, level, almost_full, overflow
    );
    modport slave (
        input  pix_valid, pix_rgb, dout_ready, clr_ovf,
        output dout_valid, dout_rgb, dout_last, level, almost_full, overflow
    );
endinterface

// File: rtl/cte_rgb_out_buffer_fifo_mem.sv
// cte_fifo_mem: DEPTH x rgb_t register array, synchronous write, asynchronous read.
module cte_fifo_mem
    import cte_rgb_out_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  rgb_t              i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output rgb_t              o_rdata
);
    rgb_t r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cte_rgb_out_buffer.sv
// cte_rgb_out_buffer: FWFT FIFO capturing unstallable CTE rgb_out pixels and draining them
// to the frame sink with end-of-frame marking, almost_full back-pressure and sticky overflow.
module cte_rgb_out_buffer
    import cte_rgb_out_buffer_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int AF_MARGIN     = 4,
    parameter int PIX_PER_FRAME = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    cte_rgb_out_buffer_if.slave   bus
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = clog2(PIX_PER_FRAME);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_overflow;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_last;
    rgb_t             w_rd_data;

    assign w_valid = r_level != '0;
    assign w_full  = r_level == LVL_W'(DEPTH);
    assign w_pop   = w_valid && bus.dout_ready;
    // a full FIFO still accepts a pixel when the head leaves in the same cycle
    assign w_push  = bus.pix_valid && (!w_full || w_pop);
    assign w_drop  = bus.pix_valid && w_full && !w_pop;
    assign w_last  = w_valid && r_out_cnt == CNT_W'(PIX_PER_FRAME - 1);

    cte_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.pix_rgb),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_out_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            if (w_pop) r_out_cnt <= w_last ? '0 : r_out_cnt + 1'b1;
            r_overflow <= w_drop ? 1'b1 : (bus.clr_ovf ? 1'b0 : r_overflow);
        end
    end

    assign bus.dout_valid  = w_valid;
    assign bus.dout_rgb    = w_valid ? w_rd_data : '0;
    assign bus.dout_last   = w_last;
    assign bus.level       = r_level;
    assign bus.almost_full = r_level >= LVL_W'(DEPTH - AF_MARGIN);
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_cte_rgb_out_buffer.sv
// tb_cte_rgb_out_buffer: directed checks of reset, FWFT hold, fill/overflow, full push+pop,
// frame-last cadence under random back-pressure, overflow clear and mid-frame reset.
module tb_cte_rgb_out_buffer;
    import cte_rgb_out_buffer_pkg::*;

    localparam int PPF = 500;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    rgb_t q[$];
    rgb_t exp_fill[16];
    rgb_t v;

    always #5 clk = ~clk;

    cte_rgb_out_buffer_if #(.LVL_W(5)) bus ();

    cte_rgb_out_buffer #(
        .DEPTH         (16),
        .AF_MARGIN     (4),
        .PIX_PER_FRAME (PPF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // random-ready stream with a queue model; records the pop indices that carry dout_last
    task automatic run_stream(input int n, input int exp_lasts, input int max_cyc);
        int sent = 0;
        int pops = 0;
        int lasts = 0;
        int cyc = 0;
        int last_idx[$];
        rgb_t d;
        while (pops < n && cyc < max_cyc) begin
            bus.dout_ready = $urandom_range(0, 9) < 7;
            bus.pix_valid  = sent < n && q.size() < 12 && $urandom_range(0, 3) != 0;
            d = rgb_t'($urandom);
            bus.pix_rgb = d;
            chk("stream_valid", 32'(bus.dout_valid), 32'(q.size() != 0));
            chk("stream_last", 32'(bus.dout_last), 32'(q.size() != 0 && pops % PPF == PPF - 1));
            if (q.size() != 0) chk("stream_rgb", 32'(bus.dout_rgb), 32'(q[0]));
            if (bus.dout_ready && q.size() != 0) begin
                if (bus.dout_last) begin
                    lasts++;
                    last_idx.push_back(pops);
                end
                void'(q.pop_front());
                pops++;
            end
            if (bus.pix_valid) begin
                q.push_back(d);
                sent++;
            end
            tick();
            cyc++;
        end
        bus.pix_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        chk("stream_pops", 32'(pops), 32'(n));
        chk("stream_last_cnt", 32'(lasts), 32'(exp_lasts));
        for (int i = 0; i < last_idx.size(); i++)
            chk("stream_last_idx", 32'(last_idx[i]), 32'(PPF * (i + 1) - 1));
    endtask

    initial begin
        // T1 reset with pix_valid asserted
        reset = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_rgb = 24'h555555;
        bus.dout_ready = 1'b0;
        bus.clr_ovf = 1'b0;
        tick();
        tick();
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_af", 32'(bus.almost_full), 0);
        chk("rst_rgb", 32'(bus.dout_rgb), 0);
        chk("rst_last", 32'(bus.dout_last), 0);
        // T2 single pixel, held under back-pressure
        reset = 1'b0;
        bus.pix_rgb = 24'h12AB34;
        tick();
        bus.pix_valid = 1'b0;
        chk("t2_valid", 32'(bus.dout_valid), 1);
        chk("t2_rgb", 32'(bus.dout_rgb), 32'h12AB34);
        chk("t2_level", 32'(bus.level), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_rgb", 32'(bus.dout_rgb), 32'h12AB34);
            chk("t2_hold_valid", 32'(bus.dout_valid), 1);
        end
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        chk("t2_empty_valid", 32'(bus.dout_valid), 0);
        chk("t2_empty_level", 32'(bus.level), 0);
        chk("t2_empty_rgb", 32'(bus.dout_rgb), 0);
        // T3 fill to full, one drop, drain in order
        for (int i = 0; i < 16; i++) begin
            exp_fill[i] = 24'hA00000 + rgb_t'(i) * 24'h010101;
            bus.pix_valid = 1'b1;
            bus.pix_rgb = exp_fill[i];
            tick();
            if (i == 10) chk("t3_af_11", 32'(bus.almost_full), 0);
            if (i == 11) chk("t3_af_12", 32'(bus.almost_full), 1);
        end
        chk("t3_level_16", 32'(bus.level), 16);
        chk("t3_ovf_before", 32'(bus.overflow), 0);
        bus.pix_rgb = 24'hDEAD00;
        tick();
        bus.pix_valid = 1'b0;
        chk("t3_drop_level", 32'(bus.level), 16);
        chk("t3_drop_ovf", 32'(bus.overflow), 1);
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain_rgb", 32'(bus.dout_rgb), 32'(exp_fill[i]));
            tick();
        end
        bus.dout_ready = 1'b0;
        chk("t3_drained", 32'(bus.dout_valid), 0);
        chk("t3_ovf_sticky", 32'(bus.overflow), 1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("t3_clr", 32'(bus.overflow), 0);
        // T4 simultaneous push+pop while full
        q.delete();
        for (int i = 0; i < 16; i++) begin
            v = 24'h300000 + rgb_t'(i);
            bus.pix_valid = 1'b1;
            bus.pix_rgb = v;
            q.push_back(v);
            tick();
        end
        chk("t4_full", 32'(bus.level), 16);
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 24'h4A0000 + rgb_t'(i);
            bus.pix_rgb = v;
            chk("t4_head", 32'(bus.dout_rgb), 32'(q[0]));
            void'(q.pop_front());
            q.push_back(v);
            tick();
            chk("t4_level", 32'(bus.level), 16);
            chk("t4_ovf", 32'(bus.overflow), 0);
        end
        // T6 drop and clr_ovf together: set wins
        bus.dout_ready = 1'b0;
        bus.clr_ovf = 1'b1;
        bus.pix_rgb = 24'hBADBAD;
        tick();
        chk("t6_set_wins", 32'(bus.overflow), 1);
        chk("t6_level", 32'(bus.level), 16);
        bus.pix_valid = 1'b0;
        tick();
        bus.clr_ovf = 1'b0;
        chk("t6_clr_alone", 32'(bus.overflow), 0);
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_drain_rgb", 32'(bus.dout_rgb), 32'(q[0]));
            void'(q.pop_front());
            tick();
        end
        bus.dout_ready = 1'b0;
        chk("t4_empty", 32'(bus.level), 0);
        // T5 two frames after a reset clears the pop count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        run_stream(1000, 2, 6000);
        // T6 mid-frame reset restarts the frame count
        bus.pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.pix_rgb = 24'h777000 + rgb_t'(i);
            tick();
        end
        bus.pix_valid = 1'b0;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_mid_level", 32'(bus.level), 2);
        reset = 1'b1;
        bus.pix_valid = 1'b1;
        bus.clr_ovf = 1'b1;
        tick();
        reset = 1'b0;
        bus.pix_valid = 1'b0;
        bus.clr_ovf = 1'b0;
        bus.dout_ready = 1'b0;
        chk("t6_rst_level", 32'(bus.level), 0);
        chk("t6_rst_valid", 32'(bus.dout_valid), 0);
        chk("t6_rst_rgb", 32'(bus.dout_rgb), 0);
        q.delete();
        run_stream(500, 1, 3000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
